// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with DEPTH stages. Supports hold, bubble insertion, flush and reset.
// Also tracks per-stage valid bits, occupancy and a saturating bubble counter.
module id_ex_pipe #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 207,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_bubble,
    input  logic              i_valid_in,
    input  logic [CTRL_W-1:0] i_ctrl_in,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              o_valid_out,
    output logic [CTRL_W-1:0] o_ctrl_out,
    output logic [DATA_W-1:0] o_data_out,
    output logic [3:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    logic              r_v [DEPTH];
    logic [CTRL_W-1:0] r_c [DEPTH];
    logic [DATA_W-1:0] r_d [DEPTH];
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_load_v;
    logic [CTRL_W-1:0] w_load_c;
    logic              w_idle;
    logic              w_cnt_max;
    logic [3:0]        w_occ;

    // Control is zeroed together with the valid bit, so an invalid slot never carries control.
    assign w_load_v  = i_valid_in & ~i_bubble;
    assign w_load_c  = w_load_v ? i_ctrl_in : '0;
    assign w_idle    = i_bubble | ~i_valid_in;
    assign w_cnt_max = &r_bubble_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i] <= 1'b0;
                r_c[i] <= '0;
                r_d[i] <= '0;
            end
            r_bubble_cnt <= '0;
        end else if (i_flush) begin
            // Data keeps shifting so the datapath is identical to the normal case.
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i] <= 1'b0;
                r_c[i] <= '0;
            end
            r_d[0] <= i_data_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_d[i] <= r_d[i-1];
            end
        end else if (!i_stall) begin
            r_v[0] <= w_load_v;
            r_c[0] <= w_load_c;
            r_d[0] <= i_data_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_v[i] <= r_v[i-1];
                r_c[i] <= r_c[i-1];
                r_d[i] <= r_d[i-1];
            end
            if (w_idle && !w_cnt_max) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + 4'(r_v[i]);
        end
    end

    assign o_valid_out  = r_v[DEPTH-1];
    assign o_ctrl_out   = r_c[DEPTH-1];
    assign o_data_out   = r_d[DEPTH-1];
    assign o_occupancy  = w_occ;
    assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a queue-based pipeline model produces per-cycle expectations
// that a separate monitor compares against the DUT outputs on the falling edge.
module tb_id_ex_pipe;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 207;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, stall, flush, bubble, valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    always #5 clk = ~clk;

    id_ex_pipe #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_bubble(bubble),
        .i_valid_in(valid_in), .i_ctrl_in(ctrl_in), .i_data_in(data_in),
        .o_valid_out(valid_out), .o_ctrl_out(ctrl_out), .o_data_out(data_out),
        .o_occupancy(occupancy), .o_bubble_cnt(bubble_cnt)
    );

    typedef struct {
        bit                v;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    typedef struct {
        bit                v;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        int                occ;
        int                cnt;
    } exp_t;

    ent_t pipe[$];
    int   m_cnt = 0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pipe is a list of DEPTH entries, newest first.
    task automatic model_edge(input bit r, input bit f, input bit s, input bit b, input bit vin,
                              input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        ent_t ne;
        exp_t e;
        if (r) begin
            pipe.delete();
            for (int i = 0; i < DEPTH; i++) pipe.push_back('{v: 1'b0, c: '0, d: '0});
            m_cnt = 0;
        end else if (f) begin
            foreach (pipe[i]) begin
                pipe[i].v = 1'b0;
                pipe[i].c = '0;
            end
            pipe.push_front('{v: 1'b0, c: '0, d: d});
            void'(pipe.pop_back());
        end else if (!s) begin
            if (b)        ne = '{v: 1'b0, c: '0, d: d};
            else if (vin) ne = '{v: 1'b1, c: c,  d: d};
            else          ne = '{v: 1'b0, c: '0, d: d};
            pipe.push_front(ne);
            void'(pipe.pop_back());
            if (b || !vin) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        e.v = pipe[DEPTH-1].v;
        e.c = pipe[DEPTH-1].c;
        e.d = pipe[DEPTH-1].d;
        e.occ = 0;
        foreach (pipe[i]) if (pipe[i].v) e.occ++;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit f, input bit s, input bit b, input bit vin,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        rst = r; flush = f; stall = s; bubble = b; valid_in = vin; ctrl_in = c; data_in = d;
        @(posedge clk);
        model_edge(r, f, s, b, vin, c, d);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    // Monitor: compares whatever expectation is pending on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid_out",  DATA_W'(valid_out),  DATA_W'(e.v));
                chk("ctrl_out",   DATA_W'(ctrl_out),   DATA_W'(e.c));
                chk("data_out",   data_out,            e.d);
                chk("occupancy",  DATA_W'(occupancy),  DATA_W'(e.occ));
                chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; bubble = 1'b0; valid_in = 1'b0;
        ctrl_in = '0; data_in = '0;

        step(1, 0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, '0, '0);

        // Reset discards in-flight entries
        step(0, 0, 0, 0, 1, 16'h0011, rand_data());
        step(0, 0, 0, 0, 1, 16'h0022, rand_data());
        step(1, 0, 0, 0, 1, 16'h0033, rand_data());

        // Streaming, occupancy rising to DEPTH
        step(0, 0, 0, 0, 1, 16'h00A1, DATA_W'(32'h100));
        step(0, 0, 0, 0, 1, 16'h00A2, DATA_W'(32'h104));
        step(0, 0, 0, 0, 1, 16'h00A3, DATA_W'(32'h108));
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, '0, rand_data());

        // Load-use bubble with valid_in high
        step(0, 0, 0, 1, 1, 16'h1234, DATA_W'(32'hDEAD));
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 16'h0100 + 16'(i), rand_data());

        // Stall together with bubble, then resume
        step(0, 0, 0, 0, 1, 16'h0055, rand_data());
        step(0, 0, 1, 1, 1, 16'h0066, rand_data());
        step(0, 0, 1, 1, 0, 16'h0077, rand_data());
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 16'h0200 + 16'(i), rand_data());

        // Flush beats stall on a full pipeline
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 16'h0300 + 16'(i), rand_data());
        step(0, 1, 1, 0, 1, 16'h0399, rand_data());
        step(0, 0, 0, 0, 1, 16'h0400, rand_data());

        // Counter saturation
        step(1, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, '0, rand_data());
        step(0, 0, 0, 1, 1, 16'hBEEF, rand_data());

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 75, CTRL_W'($urandom), rand_data());
        end

        step(0, 0, 0, 0, 0, '0, '0);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline register; next generation of the single-stage ID/EX latch.
- Carries a control bundle and a data bundle from decode to execute through DEPTH register stages.
- Supports four operations: hold (stall), bubble insertion (zeroed control, data still latched), full flush, and synchronous reset.
- Tracks a valid bit per stage, reports occupancy, and keeps a saturating bubble counter for CPI analysis.

Parameters:
- CTRL_W, 16, width of control bundle (RegDst, ALUOp, ALUSrcA/B, MemRead, MemWrite, RegWrite, MemtoReg packed).
- DATA_W, 207, width of data bundle (rd1, rd2, shamt, ext, rs, rt, rd, instr, pc packed).
- DEPTH, 1, number of register stages, legal 1..8; latency = DEPTH cycles.
- CNT_W, 16, width of bubble counter.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- stall, input, 1, hold every stage unchanged.
- flush, input, 1, invalidate every stage (branch/jump redirect).
- bubble, input, 1, stage 0 latches data_in with control forced to 0 and valid 0 (load-use hazard).
- valid_in, input, 1, decode stage holds a real instruction.
- ctrl_in, input, CTRL_W, decoded control bundle.
- data_in, input, DATA_W, operand/immediate/index/instr/pc bundle.
- valid_out, output, 1, valid bit of last stage.
- ctrl_out, output, CTRL_W, control of last stage; always 0 when valid_out=0.
- data_out, output, DATA_W, data of last stage.
- occupancy, output, 4, count of valid stages (0..DEPTH).
- bubble_cnt, output, CNT_W, saturating count of invalid entries loaded into stage 0.

Behaviour:
- Per stage i (0..DEPTH-1): registers v[i], c[i], d[i]. Outputs are driven from stage DEPTH-1. occupancy is combinational popcount of v.
- Priority per cycle: rst > flush > stall > bubble > normal.
- rst: all v=0, c=0, d=0, bubble_cnt=0. valid_out=0, ctrl_out=0, data_out=0, occupancy=0 in the cycle after the rst edge. Reset asserted mid-operation discards all in-flight entries.
- flush (no rst): all v=0, all c=0. d registers shift normally (d[0]<=data_in, d[i]<=d[i-1]); data is don't-care once invalid. bubble_cnt unchanged. flush overrides a simultaneous stall.
- stall (no rst/flush): all v, c, d hold their values; bubble_cnt unchanged. A simultaneous bubble is ignored.
- bubble (no rst/flush/stall):
  - d[0]<=data_in; c[0]<=0; v[0]<=0.
  - Stages 1..DEPTH-1 shift (v/c/d[i]<=v/c/d[i-1]).
  - bubble_cnt increments.
- Normal:
  - v[0]<=valid_in.
  - c[0]<=valid_in ? ctrl_in : 0.
  - d[0]<=data_in.
  - Stages 1..DEPTH-1 shift.
  - bubble_cnt increments if valid_in=0.
- Invariant: v[i]=0 implies c[i]=0, so downstream never sees RegWrite/MemWrite from an invalid slot.
- bubble_cnt saturates at all-ones: no wrap, further increments ignored.
- Latency: an entry loaded at edge N appears on outputs after edge N+DEPTH-1, absent stalls. Each stall cycle adds one cycle.
- DEPTH=1 with flush=0, valid_in=1 is cycle-identical to the previous ID/EX latch: bubble clears control, data always latched.
- No combinational path from any input to any output except through registers; occupancy depends only on v.

Test Plan:
- Reset: DEPTH=2, load two valid entries, assert rst one cycle -> next cycle valid_out=0, ctrl_out=0, data_out=0, occupancy=0, bubble_cnt=0.
- Streaming: DEPTH=3, feed ctrl_in=0x00A1, 0x00A2, 0x00A3 on consecutive cycles with data_in=pc 0x100/0x104/0x108 -> same values emerge 3 edges later in order; occupancy rises 1,2,3.
- Load-use bubble: DEPTH=1, ctrl_in=0x1234, data_in=0xDEAD, bubble=1 -> ctrl_out=0, valid_out=0, data_out=0xDEAD, bubble_cnt=1.
- Stall vs bubble: assert stall=1 and bubble=1 together for 2 cycles with a valid entry (ctrl 0x0055) in stage 0 -> outputs unchanged, bubble_cnt unchanged. Deassert both -> normal shift resumes.
- Flush beats stall: DEPTH=4 full pipeline, stall=1 and flush=1 -> next cycle occupancy=0, all ctrl_out=0, bubble_cnt unchanged.
- Counter saturation: CNT_W=4, 20 cycles with valid_in=0 -> bubble_cnt stops at 15.
